// File: rtl/riscv_mem_arbiter_if.sv
// Bus bundle between the fetch/load-store requesters, the arbiter and the unified memory.
// The slave modport is the arbiter's view; master is the requester/memory side.
interface riscv_mem_arbiter_if #(
  parameter int AW = 16,
  parameter int DW = 32
);
  logic            if_req;
  logic [AW-1:0]   if_addr;
  logic [DW-1:0]   if_rdata;
  logic            if_ack;
  logic            d_req;
  logic            d_we;
  logic [DW/8-1:0] d_wstrb;
  logic [AW-1:0]   d_addr;
  logic [DW-1:0]   d_wdata;
  logic [DW-1:0]   d_rdata;
  logic            d_ack;
  logic            mem_en;
  logic            mem_we;
  logic [DW/8-1:0] mem_wstrb;
  logic [AW-1:0]   mem_addr;
  logic [DW-1:0]   mem_wdata;
  logic [DW-1:0]   mem_rdata;
  logic            busy;
  logic [AW-1:0]   ADDR;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_wstrb, d_addr, d_wdata, mem_rdata,
    output if_rdata, if_ack, d_rdata, d_ack, mem_en, mem_we, mem_wstrb,
           mem_addr, mem_wdata, busy, ADDR
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_wstrb, d_addr, d_wdata, mem_rdata,
    input  if_rdata, if_ack, d_rdata, d_ack, mem_en, mem_we, mem_wstrb,
           mem_addr, mem_wdata, busy, ADDR
  );
endinterface

// File: rtl/riscv_mem_arbiter.sv
// Round-robin arbiter sharing one single-port memory between fetch and load/store ports.
//
// state | meaning
// IDLE  | sample requests, grant and latch the winner
// ISSUE | single mem_en cycle for the latched access
// WAIT  | count down memory latency, capture read data at terminal count
// RESP  | ack pulse to the granted port, then back to IDLE
module riscv_mem_arbiter #(
  parameter int AW  = 16,
  parameter int DW  = 32,
  parameter int LAT = 1
) (
  input  logic                 CLK,
  input  logic                 RST,
  riscv_mem_arbiter_if.slave   bus
);
  localparam int SW = DW / 8;

  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2, RESP = 2'd3} state_t;

  state_t          state_q;
  logic [3:0]      cnt_q;
  logic            last_q;
  logic            gnt_q;
  logic            we_q;
  logic            busy_q;
  logic            mem_en_q;
  logic            mem_we_q;
  logic [SW-1:0]   mem_wstrb_q;
  logic [AW-1:0]   mem_addr_q;
  logic [DW-1:0]   mem_wdata_q;
  logic [DW-1:0]   if_rdata_q;
  logic [DW-1:0]   d_rdata_q;
  logic            if_ack_q;
  logic            d_ack_q;
  logic            grant_d;

  // 1 = data port; on contention the port that did not win last time gets it
  assign grant_d = bus.d_req & (~bus.if_req | ~last_q);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      last_q      <= 1'b1;
      gnt_q       <= 1'b0;
      we_q        <= 1'b0;
      busy_q      <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_wstrb_q <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
      if_ack_q    <= 1'b0;
      d_ack_q     <= 1'b0;
    end else begin
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_wstrb_q <= '0;
      if_ack_q    <= 1'b0;
      d_ack_q     <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.if_req || bus.d_req) begin
            state_q  <= ISSUE;
            busy_q   <= 1'b1;
            mem_en_q <= 1'b1;
            gnt_q    <= grant_d;
            last_q   <= grant_d;
            if (grant_d) begin
              we_q        <= bus.d_we;
              mem_we_q    <= bus.d_we;
              mem_wstrb_q <= bus.d_wstrb;
              mem_addr_q  <= bus.d_addr;
              mem_wdata_q <= bus.d_wdata;
            end else begin
              we_q       <= 1'b0;
              mem_addr_q <= bus.if_addr;
            end
          end
        end
        ISSUE: begin
          cnt_q   <= 4'(LAT - 1);
          state_q <= WAIT;
        end
        WAIT: begin
          if (cnt_q == 4'd0) begin
            state_q <= RESP;
            if (gnt_q) begin
              d_ack_q <= 1'b1;
              if (!we_q) d_rdata_q <= bus.mem_rdata;
            end else begin
              if_ack_q   <= 1'b1;
              if_rdata_q <= bus.mem_rdata;
            end
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        RESP: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.if_rdata  = if_rdata_q;
  assign bus.if_ack    = if_ack_q;
  assign bus.d_rdata   = d_rdata_q;
  assign bus.d_ack     = d_ack_q;
  assign bus.mem_en    = mem_en_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_wstrb = mem_wstrb_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.busy      = busy_q;
  assign bus.ADDR      = mem_addr_q;
endmodule
